// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. A raw 32-bit RISC-V
// instruction is accepted over a valid/ready handshake, its format is
// classified from the opcode, and the sign-extended XLEN-bit immediate,
// format code and illegal flag are stored in a 2-entry output queue so a
// stalled execute stage never loses a decoded instruction. A saturating
// counter tracks how many illegal opcodes have been accepted.
//
// Optional feature macro: IMM_GEN_ZICSR_EN
//   defined   -> opcode 1110011 decodes as format Z (zero-extended rs1 field)
//   undefined -> opcode 1110011 is illegal
//
// Parameters:
//   XLEN  immediate width (32 or 64)
//   CNT_W width of the illegal-opcode counter
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous queue clear (counter is kept)
//   in_valid     in_instr is valid
//   in_ready     block can accept an instruction
//   in_instr     raw 32-bit instruction
//   out_valid    head-of-queue result is valid
//   out_ready    consumer takes the head entry
//   out_imm      immediate of the head entry (0 when out_valid=0)
//   out_fmt      format code 0=R 1=I 2=S 3=B 4=U 5=J 6=Z 7=illegal
//   out_illegal  head entry has an illegal opcode
//   illegal_cnt  saturating count of accepted illegal instructions

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [2:0]      decFmt;
    logic [XLEN-1:0] decImm;

    logic [XLEN-1:0]  immMem_q [2];
    logic [2:0]       fmtMem_q [2];
    logic             rdPtr_q, rdPtr_d;
    logic             wrPtr_q, wrPtr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] illCnt_q, illCnt_d;

    logic push;
    logic pop;

    // Classify the instruction format from the opcode. The RV64 word-sized
    // opcodes are only legal when the block is built for a 64-bit datapath.
    always_comb begin
        decFmt = FMT_ILL;
        case (in_instr[6:0])
            7'b0110011: decFmt = FMT_R;
            7'b0111011: decFmt = (XLEN == 64) ? FMT_R : FMT_ILL;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b0001111: decFmt = FMT_I;
            7'b0011011: decFmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            7'b0100011: decFmt = FMT_S;
            7'b1100011: decFmt = FMT_B;
            7'b0110111,
            7'b0010111: decFmt = FMT_U;
            7'b1101111: decFmt = FMT_J;
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: decFmt = FMT_Z;
`endif
            default:    decFmt = FMT_ILL;
        endcase
    end

    // Assemble the immediate for the decoded format. Size-casting a signed
    // value sign-extends it, which avoids zero-width replications when the
    // source field is already 32 bits wide and XLEN is 32.
    always_comb begin
        decImm = '0;
        case (decFmt)
            FMT_I:   decImm = XLEN'($signed(in_instr[31:20]));
            FMT_S:   decImm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            FMT_B:   decImm = XLEN'($signed({in_instr[31], in_instr[7],
                                             in_instr[30:25], in_instr[11:8], 1'b0}));
            FMT_U:   decImm = XLEN'($signed({in_instr[31:12], 12'b0}));
            FMT_J:   decImm = XLEN'($signed({in_instr[31], in_instr[19:12],
                                             in_instr[20], in_instr[30:21], 1'b0}));
            FMT_Z:   decImm = XLEN'(in_instr[19:15]);
            default: decImm = '0;
        endcase
    end

    // in_ready never looks at out_ready, so there is no combinational path
    // through the block from the consumer back to the producer.
    assign in_ready  = (count_q != 2'd2) && !flush;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Queue bookkeeping and the illegal counter. Flush wins over everything
    // and discards a same-cycle pop; push is already blocked by in_ready.
    always_comb begin
        rdPtr_d  = rdPtr_q;
        wrPtr_d  = wrPtr_q;
        count_d  = count_q;
        illCnt_d = illCnt_q;
        if (flush) begin
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + 1'b1;
            if (pop)  rdPtr_d = rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        if (push && (decFmt == FMT_ILL) && (illCnt_q != {CNT_W{1'b1}})) begin
            illCnt_d = illCnt_q + CNT_W'(1);
        end
    end

    // State registers: pointers, occupancy and the illegal counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q  <= 1'b0;
            wrPtr_q  <= 1'b0;
            count_q  <= 2'd0;
            illCnt_q <= '0;
        end else begin
            rdPtr_q  <= rdPtr_d;
            wrPtr_q  <= wrPtr_d;
            count_q  <= count_d;
            illCnt_q <= illCnt_d;
        end
    end

    // Queue storage, written at the write pointer on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                immMem_q[i] <= '0;
                fmtMem_q[i] <= FMT_R;
            end
        end else if (push) begin
            immMem_q[wrPtr_q] <= decImm;
            fmtMem_q[wrPtr_q] <= decFmt;
        end
    end

    // Head-of-queue outputs are forced to zero whenever nothing is valid.
    assign out_imm     = out_valid ? immMem_q[rdPtr_q] : '0;
    assign out_fmt     = out_valid ? fmtMem_q[rdPtr_q] : FMT_R;
    assign out_illegal = out_valid && (fmtMem_q[rdPtr_q] == FMT_ILL);
    assign illegal_cnt = illCnt_q;

endmodule
